clint_timer: RTL
================

CLINT_TIMER -- requirements
Module: clint_timer

Interface
REQ-001 SHALL have parameter HARTS, default 1, meaning number of harts served; legal range 1..4.
REQ-002 SHALL have parameter CLK_FREQ, default 1000000000, meaning core clock frequency in Hz.
REQ-003 SHALL have parameter RTC_FREQ, default 32768, meaning mtime tick frequency in Hz.
REQ-004 SHALL derive localparam DIVIDER = (CLK_FREQ/RTC_FREQ)/2-1, minimum value 0.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port clock  input  1  single clock; all state on its rising edge.
REQ-007 SHALL have port mem_valid  input  1  access request, one access per asserted cycle.
REQ-008 SHALL have port mem_addr  input  16  byte offset inside the CLINT window, word aligned.
REQ-009 SHALL have port mem_wstrb  input  4  byte write strobes; all zero means read.
REQ-010 SHALL have port mem_wdata  input  32  write data.
REQ-011 SHALL have port mem_rdata  output  32  registered read data.
REQ-012 SHALL have port mem_ready  output  1  access completion pulse.
REQ-013 SHALL have port msip  output  HARTS  software interrupt per hart.
REQ-014 SHALL have port mtip  output  HARTS  timer interrupt per hart.

Function
REQ-015 Map: msip[h] at 0x0000+4h (bit 0 only); mtimecmp[h] at 0x4000+8h (lo) and +4 (hi); mtime at 0xBFF8 (lo) and 0xBFFC (hi).
REQ-016 mem_ready SHALL assert exactly one cycle after each mem_valid cycle; back-to-back valids give back-to-back readies; no stalls.
REQ-017 mem_rdata SHALL be valid in the mem_ready cycle and SHALL be 0 otherwise.
REQ-018 Reads of unmapped offsets, or of harts >= HARTS, SHALL return 0; writes to them SHALL be ignored.
REQ-019 Writes SHALL update only the bytes whose mem_wstrb bit is set; msip bits 31:1 read 0.
REQ-020 Tick counter SHALL count 0..DIVIDER and wrap, toggling an internal rtc phase at each wrap.
REQ-021 mtime (64 bit) SHALL increment by 1 on each rtc rising phase, i.e. every 2*(DIVIDER+1) clocks, and SHALL wrap from all-ones to 0.
REQ-022 A write to mtime in the same cycle as an increment SHALL take priority; that increment is dropped, not deferred.
REQ-023 mtip[h] SHALL be registered as (mtime >= mtimecmp[h]), unsigned 64-bit, evaluated one cycle after any change of either operand.
REQ-024 msip[h] SHALL equal the stored msip bit with no extra latency beyond the write cycle.
REQ-025 A read in the same cycle as a write to the same register SHALL return the pre-write value.

Reset
REQ-026 While reset=1: mtime=0, tick counter=0, rtc phase=0, mtimecmp[h]=all ones, msip=0, mtip=0, mem_ready=0, mem_rdata=0.
REQ-027 An access in flight when reset asserts SHALL be discarded; no mem_ready SHALL follow reset release for it.

Configuration
REQ-028 Macro CLINT_RTC_DIV_EN: defined -> mtime increments per REQ-020/021; undefined -> divider logic absent and mtime increments every clock.

Verification
REQ-029 Reset, read 0x4000 and 0x4004 -> 0xFFFFFFFF each; read 0xBFF8 -> 0; mtip=0.
REQ-030 CLK_FREQ=1000000, RTC_FREQ=125000 (DIVIDER=3), run 80 clocks -> mtime=10.
REQ-031 Write mtimecmp[0]=5 (hi=0) -> mtip[0] rises one cycle after mtime reaches 5; write mtimecmp hi=1 -> mtip[0] falls.
REQ-032 HARTS=2, write 0x0004 data 1 strobe 0x1 -> msip=2'b10; read 0x0008 -> 0, ready after one cycle.
REQ-033 Write mtime lo=0xFFFFFFFF, hi=0 then one tick -> mtime hi=1, lo=0; write coinciding with tick -> written value held.
REQ-034 Assert reset mid-write to 0x4000 -> no mem_ready after release, mtimecmp[0]=all ones.

Source files
------------

// File: rtl/clint_timer.sv
// Core-local interruptor: per-hart msip/mtimecmp registers, 64-bit mtime, registered mtip.
// Define CLINT_RTC_DIV_EN to advance mtime from the divided rtc phase instead of every clock.
module clint_timer #(
    parameter int HARTS    = 1,
    parameter int CLK_FREQ = 1000000000,
    parameter int RTC_FREQ = 32768
) (
    input  logic             reset,
    input  logic             clock,
    input  logic             mem_valid,
    input  logic [15:0]      mem_addr,
    input  logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_wdata,
    output logic [31:0]      mem_rdata,
    output logic             mem_ready,
    output logic [HARTS-1:0] msip,
    output logic [HARTS-1:0] mtip
);

    // Bus handshake: every mem_valid cycle is accepted (no stalls); mem_ready pulses
    // exactly one cycle later, carrying mem_rdata for reads. mem_rdata is 0 in every
    // other cycle and for writes.

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strobes);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strobes[i]) result[8*i +: 8] = new_word[8*i +: 8];
        end
        return result;
    endfunction

    logic             wr_en;
    logic             rd_en;
    logic             aligned;
    logic             hi_word;
    logic             mtime_sel;
    logic [HARTS-1:0] msip_sel;
    logic [HARTS-1:0] cmp_sel;
    logic             tick;
    logic [63:0]      mtime;
    logic [63:0]      mtime_next;
    logic [63:0]      mtimecmp [HARTS];
    logic [31:0]      rd_data;

    assign wr_en     = mem_valid && (mem_wstrb != 4'b0000);
    assign rd_en     = mem_valid && (mem_wstrb == 4'b0000);
    assign aligned   = (mem_addr[1:0] == 2'b00);
    assign hi_word   = mem_addr[2];
    assign mtime_sel = aligned && (mem_addr[15:3] == 13'h17FF);

    // Hart decode: only harts below HARTS get a select, so other offsets fall through to 0.
    always_comb begin
        msip_sel = '0;
        cmp_sel  = '0;
        for (int h = 0; h < HARTS; h++) begin
            msip_sel[h] = aligned && (mem_addr[15:2] == 14'(h));
            cmp_sel[h]  = aligned && (mem_addr[15:3] == 13'(h + 'h800));
        end
    end

`ifdef CLINT_RTC_DIV_EN
    localparam int DIV_RAW = (CLK_FREQ / RTC_FREQ) / 2 - 1;
    localparam int DIVIDER = (DIV_RAW > 0) ? DIV_RAW : 0;
    localparam int CNT_W   = (DIVIDER > 0) ? $clog2(DIVIDER + 1) : 1;

    logic [CNT_W-1:0] tick_cnt;
    logic             rtc_phase;
    logic             cnt_wrap;

    assign cnt_wrap = (tick_cnt == CNT_W'(DIVIDER));
    // The wrap that raises rtc_phase is the mtime increment point.
    assign tick     = cnt_wrap && !rtc_phase;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt  <= '0;
            rtc_phase <= 1'b0;
        end else if (cnt_wrap) begin
            tick_cnt  <= '0;
            rtc_phase <= ~rtc_phase;
        end else begin
            tick_cnt  <= tick_cnt + 1'b1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // A bus write to mtime wins over a coincident tick; that tick is lost.
    always_comb begin
        mtime_next = mtime;
        if (wr_en && mtime_sel) begin
            if (hi_word) mtime_next[63:32] = merge_bytes(mtime[63:32], mem_wdata, mem_wstrb);
            else         mtime_next[31:0]  = merge_bytes(mtime[31:0], mem_wdata, mem_wstrb);
        end else if (tick) begin
            mtime_next = mtime + 64'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) mtime <= '0;
        else       mtime <= mtime_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            msip <= '0;
            for (int h = 0; h < HARTS; h++) mtimecmp[h] <= '1;
        end else begin
            for (int h = 0; h < HARTS; h++) begin
                if (wr_en && cmp_sel[h]) begin
                    if (hi_word) mtimecmp[h][63:32] <= merge_bytes(mtimecmp[h][63:32], mem_wdata, mem_wstrb);
                    else         mtimecmp[h][31:0]  <= merge_bytes(mtimecmp[h][31:0], mem_wdata, mem_wstrb);
                end
                if (wr_en && msip_sel[h] && mem_wstrb[0]) msip[h] <= mem_wdata[0];
            end
        end
    end

    // Compare the current register values so mtip trails either operand by one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mtip <= '0;
        end else begin
            for (int h = 0; h < HARTS; h++) mtip[h] <= (mtime >= mtimecmp[h]);
        end
    end

    always_comb begin
        rd_data = '0;
        for (int h = 0; h < HARTS; h++) begin
            if (msip_sel[h]) rd_data = {31'b0, msip[h]};
            if (cmp_sel[h])  rd_data = hi_word ? mtimecmp[h][63:32] : mtimecmp[h][31:0];
        end
        if (mtime_sel) rd_data = hi_word ? mtime[63:32] : mtime[31:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_ready <= mem_valid;
            mem_rdata <= rd_en ? rd_data : 32'h0;
        end
    end

endmodule
